// File: rtl/signed_divider.sv
`default_nettype none
// ------------------------------------------------------------------
// signed_divider: multi-cycle restoring divider for two's-complement
// operands, quotient truncated toward zero.  Rev 1.0
// ------------------------------------------------------------------
module signed_divider #(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] quotient,
  output logic signed [N-1:0] remainder,
  output logic                div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   bmag_q, bmag_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   remo_q, remo_d;
  logic           dbz_q, dbz_d;

  logic [N-1:0]   w_amag;
  logic [N-1:0]   w_bmag;
  logic [N:0]     w_shifted;
  logic [N:0]     w_diff;
  logic           w_qbit;
  logic [N-1:0]   w_step_rem;
  logic [N-1:0]   w_step_quo;

  assign w_amag = a[N-1] ? ('0 - a) : a;
  assign w_bmag = b[N-1] ? ('0 - b) : b;

  // Quotient bits shift into the dividend register as its MSBs are consumed.
  assign w_shifted  = {rem_q, dvd_q[N-1]};
  assign w_diff     = w_shifted - {1'b0, bmag_q};
  assign w_qbit     = ~w_diff[N];
  assign w_step_rem = w_qbit ? w_diff[N-1:0] : w_shifted[N-1:0];
  assign w_step_quo = {dvd_q[N-2:0], w_qbit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dvd_d  = w_amag;
          rem_d  = '0;
          bmag_d = w_bmag;
          qneg_d = a[N-1] ^ b[N-1];
          rneg_d = a[N-1];
          if (b == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            quot_d  = '1;
            remo_d  = a;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = CW'(N);
          end
        end
      end
      RUN: begin
        rem_d = w_step_rem;
        dvd_d = w_step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quot_d  = qneg_q ? ('0 - w_step_quo) : w_step_quo;
          remo_d  = rneg_q ? ('0 - w_step_rem) : w_step_rem;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_divider.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_signed_divider: vector table, corner sequences and random
// operands against a plain-arithmetic reference.  Rev 1.0
// ------------------------------------------------------------------
module tb_signed_divider;
  localparam int N = 32;
  localparam logic signed [31:0] MINV = 32'sh8000_0000;
  localparam logic signed [31:0] MAXV = 32'sh7FFF_FFFF;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic signed [N-1:0] a = '0;
  logic signed [N-1:0] b = '0;
  logic                busy, done, div_by_zero;
  logic signed [N-1:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  signed_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [31:0] q;
    logic signed [31:0] r;
    logic               z;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for done with a cycle budget; cyc counts from the start-sampling edge.
  task automatic wait_done(inout int cyc, output logic saw_busy);
    saw_busy = 1'b0;
    while (!done && cyc < 100) begin
      if (busy) saw_busy = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: done not seen after %0d cycles", cyc);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that raised done.
  task automatic do_div(input logic signed [31:0] ai, input logic signed [31:0] bi,
                        output int cyc, output logic saw_busy);
    start = 1'b1; a = ai; b = bi;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 1;
    wait_done(cyc, saw_busy);
  endtask

  function automatic void model(input logic signed [31:0] ai, input logic signed [31:0] bi,
                                output logic signed [31:0] q, output logic signed [31:0] r,
                                output logic z);
    longint la, lb;
    la = ai; lb = bi;
    if (bi == 0) begin
      q = -1; r = ai; z = 1'b1;
    end else begin
      q = 32'(la / lb); r = 32'(la % lb); z = 1'b0;
    end
  endfunction

  function automatic logic signed [31:0] pick(input int mode);
    logic signed [31:0] sp [5];
    sp = '{32'sd0, 32'sd1, -32'sd1, MINV, MAXV};
    case (mode)
      0: pick = $urandom;
      1: pick = $signed($urandom_range(0, 600)) - 32'sd300;
      default: pick = sp[$urandom_range(0, 4)];
    endcase
  endfunction

  initial begin
    vec_t vecs [12];
    int cyc;
    logic sb;
    logic signed [31:0] eq, er, ra, rb, q0;
    logic ez;
    longint lhs;

    vecs[0]  = '{32'sd7,    32'sd2,    32'sd3,  32'sd1,    1'b0};
    vecs[1]  = '{-32'sd7,   32'sd2,   -32'sd3, -32'sd1,    1'b0};
    vecs[2]  = '{32'sd7,   -32'sd2,   -32'sd3,  32'sd1,    1'b0};
    vecs[3]  = '{-32'sd7,  -32'sd2,    32'sd3, -32'sd1,    1'b0};
    vecs[4]  = '{MINV,     -32'sd1,    MINV,    32'sd0,    1'b0};
    vecs[5]  = '{MINV,      32'sd1,    MINV,    32'sd0,    1'b0};
    vecs[6]  = '{32'sd1234, 32'sd0,   -32'sd1,  32'sd1234, 1'b1};
    vecs[7]  = '{32'sd0,    32'sd5,    32'sd0,  32'sd0,    1'b0};
    vecs[8]  = '{32'sd5,    32'sd7,    32'sd0,  32'sd5,    1'b0};
    vecs[9]  = '{-32'sd1,   MINV,      32'sd0, -32'sd1,    1'b0};
    vecs[10] = '{MAXV,      MINV,      32'sd0,  MAXV,      1'b0};
    vecs[11] = '{MINV,      MINV,      32'sd1,  32'sd0,    1'b0};

    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_q",    64'(quotient), 64'd0);
    check("reset_r",    64'(remainder), 64'd0);
    check("reset_dbz",  64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_div(vecs[i].a, vecs[i].b, cyc, sb);
      check($sformatf("vec%0d_q", i),   64'(quotient),    64'(vecs[i].q));
      check($sformatf("vec%0d_r", i),   64'(remainder),   64'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].z));
      check($sformatf("vec%0d_lat", i), 64'(cyc), (vecs[i].b == 0) ? 64'd1 : 64'(N + 1));
      check($sformatf("vec%0d_busy", i), 64'(sb), (vecs[i].b == 0) ? 64'd0 : 64'd1);
      q0 = quotient;
      @(posedge clk); #1;
      check($sformatf("vec%0d_pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d_hold", i),  64'(quotient), 64'(q0));
    end

    // Start pulse during RUN with new operands must be ignored.
    start = 1'b1; a = 32'sd100; b = 32'sd7;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    start = 1'b1; a = 32'sd5; b = 32'sd5;
    @(posedge clk); #1;
    start = 1'b0; cyc++;
    wait_done(cyc, sb);
    check("busy_start_q", 64'(quotient), 64'(32'sd14));
    check("busy_start_r", 64'(remainder), 64'(32'sd2));
    check("busy_start_lat", 64'(cyc), 64'(N + 1));
    // Back-to-back start issued in the DONE cycle.
    do_div(32'sd5, 32'sd5, cyc, sb);
    check("b2b_q", 64'(quotient), 64'(32'sd1));
    check("b2b_r", 64'(remainder), 64'(32'sd0));
    check("b2b_lat", 64'(cyc), 64'(N + 1));

    // Asynchronous reset mid-run discards the division.
    start = 1'b1; a = 32'sd100; b = 32'sd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_q",    64'(quotient), 64'd0);
    check("arst_r",    64'(remainder), 64'd0);
    sb = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) sb = 1'b1; end
    check("arst_quiet", 64'(sb), 64'd0);
    rst_n = 1'b1;
    do_div(32'sd9, 32'sd3, cyc, sb);
    check("post_rst_q",   64'(quotient), 64'(32'sd3));
    check("post_rst_r",   64'(remainder), 64'(32'sd0));
    check("post_rst_lat", 64'(cyc), 64'(N + 1));

    // Random operands, issued back-to-back.
    for (int i = 0; i < 1500; i++) begin
      ra = pick($urandom_range(0, 2));
      rb = pick($urandom_range(0, 2));
      model(ra, rb, eq, er, ez);
      do_div(ra, rb, cyc, sb);
      check($sformatf("rnd%0d_q %0d/%0d", i, ra, rb), 64'(quotient), 64'(eq));
      check($sformatf("rnd%0d_r %0d/%0d", i, ra, rb), 64'(remainder), 64'(er));
      check($sformatf("rnd%0d_dbz", i), 64'(div_by_zero), 64'(ez));
      if (rb != 0) begin
        lhs = longint'(quotient) * longint'(rb) + longint'(remainder);
        check($sformatf("rnd%0d_ident", i), 64'(32'(lhs)), 64'(ra));
        check($sformatf("rnd%0d_rmag", i),
              64'((remainder < 0 ? -longint'(remainder) : longint'(remainder)) <
                  (rb < 0 ? -longint'(rb) : longint'(rb))), 64'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
